// File: rtl/heartbeat_analyzer.sv
// Heartbeat presence and rhythm-regularity detector for the AED front end.
// Qualifies R-wave edges against a refractory window and tracks inter-beat intervals.
module heartbeat_analyzer #(
   parameter int TICK_W  = 12,
   parameter int REFRACT = 50,
   parameter int MIN_IBI = 300,
   parameter int MAX_IBI = 1500,
   parameter int TOL     = 125,
   parameter int NREG    = 4,
   parameter int TIMEOUT = 2000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick,
   input  logic              beat,
   output logic              H,
   output logic              R,
   output logic [TICK_W-1:0] ibi,
   output logic              ibi_valid
);

   localparam int CNT_W = $clog2(NREG + 1);
   localparam logic [TICK_W-1:0] REFRACT_T = TICK_W'(REFRACT);
   localparam logic [TICK_W-1:0] MIN_T     = TICK_W'(MIN_IBI);
   localparam logic [TICK_W-1:0] MAX_T     = TICK_W'(MAX_IBI);
   localparam logic [TICK_W-1:0] TIMEOUT_T = TICK_W'(TIMEOUT);
   localparam logic [TICK_W:0]   TOL_T     = (TICK_W + 1)'(TOL);
   localparam logic [CNT_W-1:0]  NREG_C    = CNT_W'(NREG);

   typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, TRACK = 2'd2} state_t;

   // Extra bit keeps the magnitude exact for any pair of TICK_W-bit intervals.
   function automatic logic [TICK_W:0] abs_diff(input logic [TICK_W-1:0] a,
                                                input logic [TICK_W-1:0] b);
      if (a >= b) return {1'b0, a} - {1'b0, b};
      else        return {1'b0, b} - {1'b0, a};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c >= NREG_C) return NREG_C;
      else             return c + CNT_W'(1);
   endfunction

   state_t            state, state_nxt;
   logic              beat_q;
   logic              beat_rise, accept, timeout, in_range, qualify, load_ibi;
   logic [TICK_W-1:0] ivl, ivl_nxt, prev;
   logic [CNT_W-1:0]  good_cnt, good_nxt;

   assign beat_rise = beat & ~beat_q;
   assign accept    = beat_rise && ((state == IDLE) || (ivl >= REFRACT_T));
   assign timeout   = (ivl >= TIMEOUT_T);
   assign in_range  = (ivl >= MIN_T) && (ivl <= MAX_T);
   assign qualify   = in_range && (abs_diff(ivl, prev) <= TOL_T);

   always_comb begin
      if (accept)                         ivl_nxt = '0;
      else if (tick && (ivl < TIMEOUT_T)) ivl_nxt = ivl + TICK_W'(1);
      else                                ivl_nxt = ivl;
   end

   // An accepted beat wins over a coincident timeout.
   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      load_ibi  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = ACQUIRE;
         end
         ACQUIRE: begin
            if (accept) begin
               state_nxt = TRACK;
               load_ibi  = 1'b1;
               good_nxt  = in_range ? CNT_W'(1) : '0;
            end else if (timeout) begin
               state_nxt = IDLE;
            end
         end
         TRACK: begin
            if (accept) begin
               load_ibi = 1'b1;
               good_nxt = qualify ? sat_inc(good_cnt) : '0;
            end else if (timeout) begin
               state_nxt = IDLE;
               good_nxt  = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // beat_q presets high so a level already present at reset release is not an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         beat_q    <= 1'b1;
         ivl       <= '0;
         prev      <= '0;
         good_cnt  <= '0;
         ibi       <= '0;
         ibi_valid <= 1'b0;
         H         <= 1'b0;
         R         <= 1'b0;
      end else begin
         state     <= state_nxt;
         beat_q    <= beat;
         ivl       <= ivl_nxt;
         good_cnt  <= good_nxt;
         ibi_valid <= load_ibi;
         if (load_ibi) begin
            ibi  <= ivl;
            prev <= ivl;
         end
         H <= (state == TRACK);
         R <= (state == TRACK) && (good_cnt == NREG_C);
      end
   end

endmodule
